// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/exec/mem/writeback with
// memory handshakes, a wait timeout, sticky halt with error code and an instret counter.
module multicycle_controller #(
    parameter int BE_W    = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              opcode,
    input  logic [2:0]              func3,
    input  logic                    alu_branch,
    input  logic [$clog2(BE_W)-1:0] addr_lo,
    input  logic                    im_ready,
    input  logic                    dm_ready,
    output logic                    im_req,
    output logic                    ir_we,
    output logic                    dm_req,
    output logic [BE_W-1:0]         dm_w_en,
    output logic                    wb_en,
    output logic                    wb_sel,
    output logic                    alu_src1_sel,
    output logic                    alu_src2_sel,
    output logic                    jb_src1_sel,
    output logic                    pc_we,
    output logic                    next_pc_sel,
    output logic                    halt,
    output logic [1:0]              err,
    output logic [CNT_W-1:0]        instret
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TW-1:0]    TW_ONE  = TW'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    localparam logic [4:0] OP_RR     = 5'b01100;
    localparam logic [4:0] OP_RI     = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_ECALL  = 5'b11100;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_r, state_next_s;
    logic [TW-1:0]     wait_cnt_r;
    logic              taken_r, wb_en_r, wb_sel_r;
    logic [BE_W-1:0]   mask_r;
    logic [1:0]        err_r, err_next_s;
    logic [CNT_W-1:0]  instret_r;
    logic              retire_s, ready_s, timeout_s;
    logic              legal_s, is_load_s, is_store_s, is_ecall_s, writes_s, taken_s;
    logic              src1_s, src2_s, jb_s, f3_ok_s, aligned_s;
    logic [BE_W-1:0]   mask_s;

    // Opcode class decode and store byte-mask / alignment from func3 and addr_lo.
    always_comb begin
        legal_s    = 1'b0;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        is_ecall_s = 1'b0;
        writes_s   = 1'b0;
        taken_s    = 1'b0;
        src1_s     = 1'b0;
        src2_s     = 1'b0;
        jb_s       = 1'b0;
        case (opcode)
            OP_RR:     begin legal_s = 1'b1; writes_s = 1'b1; src2_s = 1'b1; end
            OP_RI:     begin legal_s = 1'b1; writes_s = 1'b1; end
            OP_LOAD:   begin legal_s = 1'b1; writes_s = 1'b1; is_load_s = 1'b1; end
            OP_STORE:  begin legal_s = 1'b1; is_store_s = 1'b1; end
            OP_BRANCH: begin legal_s = 1'b1; src2_s = 1'b1; taken_s = alu_branch; end
            OP_JAL:    begin legal_s = 1'b1; writes_s = 1'b1; src1_s = 1'b1; taken_s = 1'b1; end
            OP_JALR:   begin legal_s = 1'b1; writes_s = 1'b1; src1_s = 1'b1; jb_s = 1'b1; taken_s = 1'b1; end
            OP_LUI:    begin legal_s = 1'b1; writes_s = 1'b1; end
            OP_AUIPC:  begin legal_s = 1'b1; writes_s = 1'b1; src1_s = 1'b1; end
            OP_ECALL:  begin legal_s = 1'b1; is_ecall_s = 1'b1; end
            default:   begin legal_s = 1'b0; end
        endcase

        mask_s    = '0;
        f3_ok_s   = 1'b1;
        aligned_s = 1'b1;
        case (func3)
            3'b000: mask_s = BE_W'(4'h1) << addr_lo;
            3'b001: begin mask_s = BE_W'(4'h3) << addr_lo; aligned_s = ~addr_lo[0]; end
            3'b010: begin mask_s = BE_W'(4'hF) << addr_lo; aligned_s = (addr_lo[1:0] == 2'b00); end
            3'b011: begin
                if (BE_W == 8) begin
                    mask_s    = '1;
                    aligned_s = (addr_lo == '0);
                end else begin
                    f3_ok_s = 1'b0;
                end
            end
            default: f3_ok_s = 1'b0;
        endcase
    end

    assign ready_s   = (state_r == S_FETCH) ? im_ready : dm_ready;
    assign timeout_s = (TIMEOUT > 0) && (wait_cnt_r == TO_LAST) && !ready_s;

    // Next-state, error code and retire decision.
    always_comb begin
        state_next_s = state_r;
        err_next_s   = err_r;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (im_ready) begin
                    state_next_s = S_DECODE;
                end else if (timeout_s) begin
                    state_next_s = S_HALT;
                    err_next_s   = 2'd3;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: state_next_s = S_EXEC;
            S_EXEC: begin
                if (!legal_s || (is_store_s && !f3_ok_s)) begin
                    state_next_s = S_HALT;
                    err_next_s   = 2'd1;
                end else if (is_store_s && !aligned_s) begin
                    state_next_s = S_HALT;
                    err_next_s   = 2'd2;
                end else if (is_ecall_s) begin
                    state_next_s = S_HALT;
                    err_next_s   = 2'd0;
                    retire_s     = 1'b1;
                end else if (is_load_s || is_store_s) begin
                    state_next_s = S_MEM;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_MEM: begin
                if (dm_ready) begin
                    state_next_s = S_WB;
                end else if (timeout_s) begin
                    state_next_s = S_HALT;
                    err_next_s   = 2'd3;
                end else begin
                    state_next_s = S_MEM;
                end
            end
            S_WB: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_HALT:  state_next_s = S_HALT;
            default: state_next_s = S_HALT;
        endcase
    end

    // State, error code and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            err_r     <= 2'd0;
            instret_r <= '0;
        end else begin
            state_r <= state_next_s;
            err_r   <= err_next_s;
            if (retire_s) begin
                instret_r <= instret_r + CNT_ONE;
            end
        end
    end

    // Wait counter restarts on every state change and counts cycles without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= '0;
        end else if ((state_r == S_FETCH || state_r == S_MEM) && !ready_s) begin
            wait_cnt_r <= wait_cnt_r + TW_ONE;
        end
    end

    // Instruction flags captured in EXEC so MEM/WB outputs depend only on registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_r  <= 1'b0;
            wb_en_r  <= 1'b0;
            wb_sel_r <= 1'b0;
            mask_r   <= '0;
        end else if (state_r == S_EXEC) begin
            taken_r  <= taken_s;
            wb_en_r  <= writes_s;
            wb_sel_r <= is_load_s;
            mask_r   <= is_store_s ? mask_s : '0;
        end
    end

    // Moore strobes; everything is forced low while reset is asserted.
    always_comb begin
        im_req       = 1'b0;
        dm_req       = 1'b0;
        dm_w_en      = '0;
        wb_en        = 1'b0;
        wb_sel       = 1'b0;
        alu_src1_sel = 1'b0;
        alu_src2_sel = 1'b0;
        jb_src1_sel  = 1'b0;
        pc_we        = 1'b0;
        next_pc_sel  = 1'b0;
        halt         = 1'b0;
        if (rst_n) begin
            case (state_r)
                S_FETCH: im_req = 1'b1;
                S_EXEC: begin
                    alu_src1_sel = src1_s;
                    alu_src2_sel = src2_s;
                    jb_src1_sel  = jb_s;
                end
                S_MEM: begin
                    dm_req  = 1'b1;
                    dm_w_en = mask_r;
                end
                S_WB: begin
                    wb_en       = wb_en_r;
                    wb_sel      = wb_sel_r;
                    pc_we       = 1'b1;
                    next_pc_sel = taken_r;
                end
                S_HALT:  halt = 1'b1;
                default: halt = 1'b0;
            endcase
        end else begin
            halt = 1'b0;
        end
        ir_we   = im_req & im_ready;
        err     = rst_n ? err_r : 2'd0;
        instret = rst_n ? instret_r : '0;
    end
endmodule
